// File: rtl/ext_ld_unit_pkg.sv
// Shared types and sizing for the external-load path feeding the BRAM unit.
// Token link structs, FSM state enum and the request-count helper live here.
package pkg_bram_if;

  localparam int unsigned WIDTH_DATA           = 8;
  localparam int unsigned WIDTH_EXT_DATA       = 32;
  localparam int unsigned WIDTH_EXT_ADDR       = 32;
  localparam int unsigned WIDTH_EXT_LENGTH     = 16;
  localparam int unsigned UNIT_EXT_DATA        = WIDTH_EXT_DATA / WIDTH_DATA;
  localparam int unsigned LENGTH_BUFF_LD       = 16;
  localparam int unsigned WIDTH_LENGTH_BUFF_LD = $clog2(LENGTH_BUFF_LD + 1);
  localparam int unsigned WIDTH_SLICE          = (UNIT_EXT_DATA > 1) ? $clog2(UNIT_EXT_DATA) : 1;

  typedef logic [WIDTH_EXT_ADDR-1:0] ext_addr_t;
  typedef logic [WIDTH_EXT_DATA-1:0] ext_io_t;
  typedef logic [WIDTH_DATA-1:0]     data_t;

  typedef struct packed {
    logic  v;
    data_t d;
  } FTk_t;

  typedef struct packed {
    logic n;
  } BTk_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fsm_ext_ld;

  // Number of external words needed to carry len tokens (ceiling division).
  function automatic logic [WIDTH_EXT_LENGTH-1:0] calc_nreq(
    input logic [WIDTH_EXT_LENGTH-1:0] len
  );
    logic [WIDTH_EXT_LENGTH:0] sum;
    logic [WIDTH_EXT_LENGTH:0] quo;
    sum = {1'b0, len} + (WIDTH_EXT_LENGTH + 1)'(UNIT_EXT_DATA - 1);
    quo = sum / (WIDTH_EXT_LENGTH + 1)'(UNIT_EXT_DATA);
    return quo[WIDTH_EXT_LENGTH-1:0];
  endfunction

endpackage

// File: rtl/ext_ld_buff.sv
// Word FIFO between the external read return and the token serializer.
// Push and pop may coincide at any occupancy; pop on empty is ignored.
module ext_ld_buff #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned WIDTH_COUNT = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_Push,
  input  logic [WIDTH-1:0]       I_Data,
  input  logic                   I_Pop,
  output logic [WIDTH-1:0]       O_Data,
  output logic                   O_Full,
  output logic                   O_Empty,
  output logic [WIDTH_COUNT-1:0] O_Count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [WIDTH_COUNT-1:0] r_count;

  logic w_pop;
  logic w_push;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign O_Empty = (r_count == '0);
  assign O_Full  = (r_count == WIDTH_COUNT'(DEPTH));
  assign O_Count = r_count;
  assign O_Data  = r_mem[r_rptr];

  assign w_pop  = I_Pop && !O_Empty;
  assign w_push = I_Push && (!O_Full || w_pop);

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= I_Data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      if (w_push && !w_pop)      r_count <= r_count + WIDTH_COUNT'(1);
      else if (w_pop && !w_push) r_count <= r_count - WIDTH_COUNT'(1);
    end
  end

endmodule

// File: rtl/ext_ld_unit.sv
// Loads Length data tokens from external memory and streams them to the BRAM unit.
// Requests are credit-limited so buffered plus in-flight words never exceed the FIFO depth.
module ext_ld_unit
  import pkg_bram_if::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        I_Req,
  input  ext_addr_t                   I_Base,
  input  logic [WIDTH_EXT_LENGTH-1:0] I_Length,
  output logic                        O_Busy,
  output logic                        O_Done,
  output logic                        O_Ext_Req,
  output ext_addr_t                   O_Ext_Addr,
  input  logic                        I_Ext_Gnt,
  input  logic                        I_Ext_Valid,
  input  ext_io_t                     I_Ext_Data,
  output FTk_t                        O_FTk,
  input  BTk_t                        I_BTk
);

  fsm_ext_ld                       r_state;
  ext_addr_t                       r_addr;
  logic [WIDTH_EXT_LENGTH-1:0]     r_req_left;
  logic [WIDTH_EXT_LENGTH-1:0]     r_tok_left;
  logic [WIDTH_LENGTH_BUFF_LD-1:0] r_outst;
  logic [WIDTH_SLICE-1:0]          r_slice;
  logic                            r_done;

  logic [WIDTH_LENGTH_BUFF_LD-1:0] w_occ;
  logic                            w_full;
  logic                            w_empty;
  ext_io_t                         w_head;
  ext_io_t                         w_shift;
  logic                            w_credit_ok;
  logic                            w_ext_req;
  logic                            w_grant;
  logic                            w_accept;
  logic                            w_push;
  logic                            w_tok_v;
  logic                            w_fire;
  logic                            w_last_tok;
  logic                            w_slice_last;
  logic                            w_pop;

  // Credit only grows while a request waits for grant, so O_Ext_Req cannot drop early.
  assign w_credit_ok = ({1'b0, w_occ} + {1'b0, r_outst})
                       < (WIDTH_LENGTH_BUFF_LD + 1)'(LENGTH_BUFF_LD);
  assign w_ext_req   = (r_state == ST_RUN) && (r_req_left != '0) && w_credit_ok;
  assign w_grant     = w_ext_req && I_Ext_Gnt;
  assign w_accept    = I_Ext_Valid && (r_outst != '0);

  assign w_tok_v      = (r_state != ST_IDLE) && !w_empty && (r_tok_left != '0);
  assign w_fire       = w_tok_v && !I_BTk.n;
  assign w_last_tok   = (r_tok_left == WIDTH_EXT_LENGTH'(1));
  assign w_slice_last = (r_slice == WIDTH_SLICE'(UNIT_EXT_DATA - 1));
  // The final token retires its word even if upper slices remain unused.
  assign w_pop        = w_fire && (w_slice_last || w_last_tok);
  assign w_push       = w_accept && (!w_full || w_pop);

  assign w_shift = w_head >> (int'(r_slice) * WIDTH_DATA);

  assign O_Busy     = (r_state != ST_IDLE);
  assign O_Done     = r_done;
  assign O_Ext_Req  = w_ext_req;
  assign O_Ext_Addr = r_addr;
  assign O_FTk.v    = w_tok_v;
  assign O_FTk.d    = w_tok_v ? w_shift[WIDTH_DATA-1:0] : '0;

  ext_ld_buff #(
    .DEPTH      (LENGTH_BUFF_LD),
    .WIDTH      (WIDTH_EXT_DATA),
    .WIDTH_COUNT(WIDTH_LENGTH_BUFF_LD)
  ) u_buff (
    .clock  (clock),
    .reset  (reset),
    .I_Push (w_push),
    .I_Data (I_Ext_Data),
    .I_Pop  (w_pop),
    .O_Data (w_head),
    .O_Full (w_full),
    .O_Empty(w_empty),
    .O_Count(w_occ)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_req_left <= '0;
      r_tok_left <= '0;
      r_outst    <= '0;
      r_slice    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_grant) begin
        r_addr     <= r_addr + ext_addr_t'(WIDTH_EXT_DATA / 8);
        r_req_left <= r_req_left - WIDTH_EXT_LENGTH'(1);
      end

      if (w_grant && !w_accept)      r_outst <= r_outst + WIDTH_LENGTH_BUFF_LD'(1);
      else if (!w_grant && w_accept) r_outst <= r_outst - WIDTH_LENGTH_BUFF_LD'(1);

      if (w_fire) begin
        r_tok_left <= r_tok_left - WIDTH_EXT_LENGTH'(1);
        r_slice    <= w_pop ? '0 : r_slice + WIDTH_SLICE'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (I_Req) begin
            if (I_Length == '0) begin
              r_done <= 1'b1;
            end else begin
              r_addr     <= I_Base;
              r_req_left <= calc_nreq(I_Length);
              r_tok_left <= I_Length;
              r_slice    <= '0;
              r_state    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_fire && w_last_tok) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else if (w_grant && (r_req_left == WIDTH_EXT_LENGTH'(1))) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_fire && w_last_tok) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_ld_unit.sv
// Directed bench for ext_ld_unit with a byte-addressed external memory model.
// Each memory byte holds the low byte of its own address, so token k of a load is (base+k)[7:0].
module tb_ext_ld_unit;
  import pkg_bram_if::*;

  logic                        clock = 1'b0;
  logic                        reset = 1'b0;
  logic                        I_Req = 1'b0;
  ext_addr_t                   I_Base = '0;
  logic [WIDTH_EXT_LENGTH-1:0] I_Length = '0;
  logic                        O_Busy;
  logic                        O_Done;
  logic                        O_Ext_Req;
  ext_addr_t                   O_Ext_Addr;
  logic                        I_Ext_Gnt = 1'b0;
  logic                        I_Ext_Valid = 1'b0;
  ext_io_t                     I_Ext_Data = '0;
  FTk_t                        O_FTk;
  BTk_t                        I_BTk = '0;

  int checks = 0;
  int errors = 0;

  // Environment state shared between the directed sequence and the negedge model.
  int        cyc = 0;
  int        done_count = 0;
  int        tok_count = 0;
  int        first_cyc = 0;
  int        last_cyc = 0;
  int        grants_t = 0;
  int        gnt_limit = 1000;
  int        max_inflight = 0;
  bit        gnt_en = 1'b1;
  bit        valid_en = 1'b1;
  bit        req_seen = 1'b0;
  bit        busy_seen = 1'b0;
  bit        prev_hold = 1'b0;
  FTk_t      prev_ftk = '0;
  ext_addr_t exp_base = '0;
  ext_addr_t pend_q[$];
  ext_addr_t addr_q[$];

  ext_ld_unit u_dut (
    .clock      (clock),
    .reset      (reset),
    .I_Req      (I_Req),
    .I_Base     (I_Base),
    .I_Length   (I_Length),
    .O_Busy     (O_Busy),
    .O_Done     (O_Done),
    .O_Ext_Req  (O_Ext_Req),
    .O_Ext_Addr (O_Ext_Addr),
    .I_Ext_Gnt  (I_Ext_Gnt),
    .I_Ext_Valid(I_Ext_Valid),
    .I_Ext_Data (I_Ext_Data),
    .O_FTk      (O_FTk),
    .I_BTk      (I_BTk)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ext_io_t mem_word(input ext_addr_t a);
    ext_io_t w;
    for (int i = 0; i < int'(UNIT_EXT_DATA); i++) w[i*WIDTH_DATA +: WIDTH_DATA] = a[7:0] + 8'(i);
    return w;
  endfunction

  // Monitor samples first, then the memory model drives for the next rising edge.
  always @(negedge clock) begin
    ext_addr_t etok;
    int        inflight;
    cyc++;
    if (O_Done)    done_count++;
    if (O_Ext_Req) req_seen = 1'b1;
    if (O_Busy)    busy_seen = 1'b1;
    if (prev_hold && O_FTk.v && I_BTk.n) chk("ftk_hold", 64'(O_FTk), 64'(prev_ftk));
    prev_hold = O_FTk.v && I_BTk.n;
    prev_ftk  = O_FTk;
    inflight  = grants_t - tok_count / int'(UNIT_EXT_DATA);
    if (inflight > max_inflight) max_inflight = inflight;
    if (O_FTk.v && !I_BTk.n) begin
      etok = exp_base + ext_addr_t'(tok_count);
      chk("token", 64'(O_FTk.d), 64'(etok[7:0]));
      if (tok_count == 0) first_cyc = cyc;
      last_cyc = cyc;
      tok_count++;
    end
    if (valid_en && pend_q.size() > 0) begin
      I_Ext_Valid = 1'b1;
      I_Ext_Data  = mem_word(pend_q.pop_front());
    end else begin
      I_Ext_Valid = 1'b0;
      I_Ext_Data  = '0;
    end
    if (O_Ext_Req && gnt_en && grants_t < gnt_limit) begin
      I_Ext_Gnt = 1'b1;
      pend_q.push_back(O_Ext_Addr);
      addr_q.push_back(O_Ext_Addr);
      grants_t++;
    end else begin
      I_Ext_Gnt = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input ext_addr_t b, input logic [WIDTH_EXT_LENGTH-1:0] l);
    tick();
    grants_t     = 0;
    addr_q.delete();
    tok_count    = 0;
    exp_base     = b;
    max_inflight = 0;
    req_seen     = 1'b0;
    busy_seen    = 1'b0;
    I_Base       = b;
    I_Length     = l;
    I_Req        = 1'b1;
    tick();
    I_Req        = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int base_cnt;
    int n;
    base_cnt = done_count;
    n = 0;
    while (done_count == base_cnt && n < max_cyc) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk(tag, 64'(done_count - base_cnt), 64'd1);
    chk({tag, "_idle"}, 64'(O_Busy), 64'd0);
  endtask

  initial begin
    int dc;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    // Reset values while reset is held low.
    #2;
    chk("rst_busy", 64'(O_Busy), 64'd0);
    chk("rst_done", 64'(O_Done), 64'd0);
    chk("rst_req", 64'(O_Ext_Req), 64'd0);
    chk("rst_addr", 64'(O_Ext_Addr), 64'd0);
    chk("rst_ftk", 64'(O_FTk), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Basic 4-word load; grant withheld for three cycles to check request hold.
    gnt_en = 1'b0;
    start(32'h0000_1000, 16'(4 * UNIT_EXT_DATA));
    chk("t1_busy", 64'(O_Busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t1_hold_req", 64'(O_Ext_Req), 64'd1);
      chk("t1_hold_addr", 64'(O_Ext_Addr), 64'h1000);
      tick();
    end
    gnt_en = 1'b1;
    wait_done("t1_done", 400);
    chk("t1_ngrant", 64'(addr_q.size()), 64'd4);
    chk("t1_addr0", 64'(addr_q[0]), 64'h1000);
    chk("t1_addr1", 64'(addr_q[1]), 64'h1004);
    chk("t1_addr2", 64'(addr_q[2]), 64'h1008);
    chk("t1_addr3", 64'(addr_q[3]), 64'h100C);
    chk("t1_ntok", 64'(tok_count), 64'(4 * UNIT_EXT_DATA));
    chk("t1_no_stall", 64'(last_cyc - first_cyc), 64'(4 * UNIT_EXT_DATA - 1));

    // Zero-length request completes from idle without any external traffic.
    dc = done_count;
    start(32'h0000_8000, 16'd0);
    chk("t2_done_hi", 64'(O_Done), 64'd1);
    chk("t2_busy", 64'(O_Busy), 64'd0);
    tick();
    chk("t2_done_lo", 64'(O_Done), 64'd0);
    repeat (3) tick();
    chk("t2_req_seen", 64'(req_seen), 64'd0);
    chk("t2_busy_seen", 64'(busy_seen), 64'd0);
    chk("t2_ndone", 64'(done_count - dc), 64'd1);

    // Address wrap at the top of the address space.
    start(32'hFFFF_FFFC, 16'(2 * UNIT_EXT_DATA));
    wait_done("t3_done", 400);
    chk("t3_ngrant", 64'(addr_q.size()), 64'd2);
    chk("t3_addr0", 64'(addr_q[0]), 64'hFFFF_FFFC);
    chk("t3_addr1", 64'(addr_q[1]), 64'h0000_0000);
    chk("t3_ntok", 64'(tok_count), 64'(2 * UNIT_EXT_DATA));

    // Downstream backpressure: credit fills to the buffer depth and the token holds.
    I_BTk.n = 1'b1;
    start(32'h0000_2034, 16'(32 * UNIT_EXT_DATA));
    repeat (40) tick();
    chk("t4_grants_held", 64'(grants_t), 64'd16);
    chk("t4_max_inflight", 64'(max_inflight), 64'd16);
    chk("t4_tok_none", 64'(tok_count), 64'd0);
    chk("t4_ftk_v", 64'(O_FTk.v), 64'd1);
    chk("t4_ftk_d", 64'(O_FTk.d), 64'h34);
    I_BTk.n = 1'b0;
    wait_done("t4_done", 2000);
    chk("t4_ntok", 64'(tok_count), 64'(32 * UNIT_EXT_DATA));
    chk("t4_ngrant", 64'(grants_t), 64'd32);
    chk("t4_max_inflight_end", 64'(max_inflight), 64'd16);

    // Partial final word: extra slices are dropped.
    start(32'h0000_3000, 16'(UNIT_EXT_DATA + 1));
    wait_done("t5_done", 400);
    chk("t5_ngrant", 64'(addr_q.size()), 64'd2);
    chk("t5_addr1", 64'(addr_q[1]), 64'h3004);
    chk("t5_ntok", 64'(tok_count), 64'(UNIT_EXT_DATA + 1));
    chk("t5_ftk_idle", 64'(O_FTk), 64'd0);

    // Reset with three reads outstanding, then their data returns late.
    gnt_limit = 3;
    valid_en  = 1'b0;
    start(32'h0000_4000, 16'(32 * UNIT_EXT_DATA));
    for (int i = 0; i < 20 && grants_t < 3; i++) tick();
    tick();
    chk("t6_grants", 64'(grants_t), 64'd3);
    chk("t6_busy", 64'(O_Busy), 64'd1);
    dc = done_count;
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(O_Busy), 64'd0);
    chk("t6_rst_req", 64'(O_Ext_Req), 64'd0);
    chk("t6_rst_addr", 64'(O_Ext_Addr), 64'd0);
    chk("t6_rst_ftk", 64'(O_FTk), 64'd0);
    chk("t6_rst_done", 64'(O_Done), 64'd0);
    tick();
    reset     = 1'b1;
    gnt_limit = 1000;
    valid_en  = 1'b1;
    repeat (6) tick();
    chk("t6_late_tok", 64'(tok_count), 64'd0);
    chk("t6_late_busy", 64'(O_Busy), 64'd0);
    chk("t6_late_ftk", 64'(O_FTk), 64'd0);
    chk("t6_late_req", 64'(O_Ext_Req), 64'd0);
    chk("t6_late_ndone", 64'(done_count - dc), 64'd0);
    start(32'h0000_5000, 16'(2 * UNIT_EXT_DATA));
    wait_done("t6_new_done", 400);
    chk("t6_new_ntok", 64'(tok_count), 64'(2 * UNIT_EXT_DATA));
    chk("t6_new_addr0", 64'(addr_q[0]), 64'h5000);
    chk("t6_new_ngrant", 64'(addr_q.size()), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_ld_unit.md
EXT_LD_UNIT -- requirements
Module: ext_ld_unit

Interface
REQ-001 SHALL have port clock  in  1  sole clock; all state updates on the rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port I_Req  in  1  load-start pulse; sampled only in ST_IDLE.
REQ-004 SHALL have port I_Base  in  ext_addr_t  byte base address on external memory.
REQ-005 SHALL have port I_Length  in  WIDTH_EXT_LENGTH  number of WIDTH_DATA words to load.
REQ-006 SHALL have port O_Busy  out  1  high in every state other than ST_IDLE.
REQ-007 SHALL have port O_Done  out  1  one-cycle completion pulse.
REQ-008 SHALL have ports O_Ext_Req (out, 1) and O_Ext_Addr (out, ext_addr_t), the external read request and its byte address.
REQ-009 SHALL have port I_Ext_Gnt  in  1  request accepted this cycle.
REQ-010 SHALL have ports I_Ext_Valid (in, 1) and I_Ext_Data (in, ext_io_t), in-order read return.
REQ-011 SHALL have ports O_FTk (out, FTk_t) and I_BTk (in, BTk_t), the token link to the downstream BRAM unit.

Function
REQ-012 SHALL use FSM states ST_IDLE, ST_RUN and ST_DRAIN.
REQ-013 SHALL leave ST_IDLE only on I_Req=1:
- Length=0: stay in ST_IDLE and pulse O_Done next cycle.
- Otherwise: latch base and length, set NReq=ceil(Length/UNIT_EXT_DATA), enter ST_RUN.
REQ-014 SHALL assert O_Ext_Req in ST_RUN only while credit>0, where credit = LENGTH_BUFF_LD − buffer occupancy − outstanding requests.
REQ-015 SHALL hold O_Ext_Req and O_Ext_Addr stable until I_Ext_Gnt.
REQ-016 SHALL compute the k-th request address as I_Base + k*(WIDTH_EXT_DATA/8), wrapping modulo 2^WIDTH_EXT_ADDR.
REQ-017 SHALL move from ST_RUN to ST_DRAIN in the cycle after the last request is granted.
REQ-018 SHALL write each I_Ext_Valid word into a LENGTH_BUFF_LD-entry ext_io_t FIFO.
REQ-019 SHALL ignore I_Ext_Valid while the outstanding-request count is 0.
REQ-020 SHALL serialize each FIFO word into UNIT_EXT_DATA tokens, least-significant WIDTH_DATA slice first.
REQ-021 SHALL discard slices beyond the total of Length tokens (partial last word).
REQ-022 SHALL drive O_FTk.v=1 with O_FTk.d = the current slice whenever a token is available.
REQ-023 SHALL consume a token only on O_FTk.v=1 and I_BTk.n=0, and SHALL hold O_FTk stable while I_BTk.n=1.
REQ-024 SHALL allow a FIFO push and pop in the same cycle, including when the FIFO is full or empty; the credit rule guarantees no overflow.
REQ-025 SHALL return to ST_IDLE and pulse O_Done for exactly one cycle after the last token is consumed.
REQ-026 SHALL ignore I_Req while O_Busy=1.
REQ-027 SHALL output the first token no earlier than 1 cycle after the corresponding I_Ext_Valid.
REQ-028 SHALL sustain 1 token/cycle with no stall when ext data returns every cycle.

Reset
REQ-029 SHALL, on reset low, immediately force:
- FSM to ST_IDLE;
- O_Busy, O_Done and O_Ext_Req to 0, and O_Ext_Addr to 0;
- O_FTk to all zero;
- FIFO pointers, occupancy, outstanding and token counters to 0.
REQ-030 SHALL drop any in-flight transfer on reset mid-operation; late I_Ext_Valid after reset SHALL be ignored per REQ-019.

Structure
REQ-031 SHALL place the FSM enum fsm_ext_ld (2-bit) in pkg_bram_if.
REQ-032 SHALL reuse LENGTH_BUFF_LD, WIDTH_LENGTH_BUFF_LD, UNIT_EXT_DATA, ext_addr_t and ext_io_t from pkg_bram_if.
REQ-033 SHALL instantiate the FIFO as sub-module ext_ld_buff (parameterized depth and width, push/pop, full/empty, occupancy count).

Verification
REQ-034 Base=0x1000, Length=4*UNIT_EXT_DATA, Gnt and Valid each next cycle, n=0 -> 4 requests at 0x1000/0x1004/0x1008/0x100C; 4*UNIT_EXT_DATA tokens in order; one O_Done pulse.
REQ-035 Length=0 -> no O_Ext_Req, O_Busy stays 0, O_Done high one cycle.
REQ-036 Base=0xFFFFFFFC, Length=2*UNIT_EXT_DATA -> addresses 0xFFFFFFFC then 0x00000000.
REQ-037 I_BTk.n=1 held for 40 cycles, Length=32*UNIT_EXT_DATA -> outstanding+occupancy never exceeds 16; O_FTk held constant; all tokens delivered once n=0.
REQ-038 Length=UNIT_EXT_DATA+1 (when UNIT_EXT_DATA>1) -> 2 requests; exactly UNIT_EXT_DATA+1 tokens; extra slices dropped.
REQ-039 Reset low in ST_RUN with 3 outstanding, then 3 late I_Ext_Valid -> all outputs 0, FSM ST_IDLE, no tokens emitted; a new I_Req completes normally.
